// File: rtl/iterative_alu.sv
// iterative_alu: execute-stage ALU with valid/ready handshakes on both sides.
// Logic and arithmetic ops finish in one cycle. Shifts run bit-serially at one
// bit per cycle, so a shift by n finishes in 1+n cycles.
// Optional build macro BARREL_SHIFT_EN: shifts use a single-cycle barrel shifter
// instead, every op has latency 1, and the SHIFT state is never entered.
// Handshake: a transfer occurs on a rising edge where valid && ready. in_ready is
// high only in IDLE. out_valid is high only in DONE. While out_valid is high,
// result and flags hold steady until out_ready is seen.
module iterative_alu #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_sel,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zf,
  output logic             cf,
  output logic             vf,
  output logic             sf,
  output logic [1:0]       dbg_state
);

  // ALU selection codes, matching the ALU control decode
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_PASS = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [3:0]         sel_q, sel_d;
  logic               zf_q, zf_d, cf_q, cf_d, vf_q, vf_d, sf_q, sf_d;

  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH:0]     add_full;
  logic [WIDTH:0]     sub_full;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_cf;
  logic               alu_vf;
  logic               is_shift;
  logic [WIDTH-1:0]   step_res;

  assign shamt     = op_b[SHAMT_W-1:0];
  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign zf        = zf_q;
  assign cf        = cf_q;
  assign vf        = vf_q;
  assign sf        = sf_q;
  assign dbg_state = state_q;

  // Single-cycle datapath on the incoming operands; used on the accept edge
  always_comb begin
    add_full = {1'b0, op_a} + {1'b0, op_b};
    sub_full = {1'b0, op_a} - {1'b0, op_b};
    alu_res  = op_b;
    alu_cf   = 1'b0;
    alu_vf   = 1'b0;
    is_shift = 1'b0;
    case (alu_sel)
      ALU_ADD: begin
        alu_res = add_full[WIDTH-1:0];
        alu_cf  = add_full[WIDTH];
        alu_vf  = (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                  (add_full[WIDTH-1] != op_a[WIDTH-1]);
      end
      ALU_SUB: begin
        alu_res = sub_full[WIDTH-1:0];
        // Carry means no borrow, i.e. a >= b unsigned
        alu_cf  = ~sub_full[WIDTH];
        alu_vf  = (op_a[WIDTH-1] != op_b[WIDTH-1]) &&
                  (sub_full[WIDTH-1] != op_a[WIDTH-1]);
      end
      ALU_AND:  alu_res = op_a & op_b;
      ALU_OR:   alu_res = op_a | op_b;
      ALU_XOR:  alu_res = op_a ^ op_b;
      ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
`ifdef BARREL_SHIFT_EN
      ALU_SLL: alu_res = op_a << shamt;
      ALU_SRL: alu_res = op_a >> shamt;
      ALU_SRA: alu_res = $unsigned($signed(op_a) >>> shamt);
`else
      // Zero-distance shifts finish immediately with the operand unchanged;
      // non-zero distances go through the serial path
      ALU_SLL, ALU_SRL, ALU_SRA: begin
        alu_res  = op_a;
        is_shift = (shamt != '0);
      end
`endif
      ALU_PASS: alu_res = op_b;
      default:  alu_res = op_b;
    endcase
  end

  // One-bit shift step of the latched value for the serial shifter
  always_comb begin
    case (sel_q)
      ALU_SLL: step_res = {result_q[WIDTH-2:0], 1'b0};
      ALU_SRA: step_res = {result_q[WIDTH-1], result_q[WIDTH-1:1]};
      default: step_res = {1'b0, result_q[WIDTH-1:1]};
    endcase
  end

  // Next-state, datapath and flag update for the IDLE/SHIFT/DONE controller
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    zf_d     = zf_q;
    cf_d     = cf_q;
    vf_d     = vf_q;
    sf_d     = sf_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sel_d = alu_sel;
          if (is_shift) begin
            result_d = op_a;
            cnt_d    = shamt;
            state_d  = S_SHIFT;
          end else begin
            result_d = alu_res;
            zf_d     = (alu_res == '0);
            sf_d     = alu_res[WIDTH-1];
            cf_d     = alu_cf;
            vf_d     = alu_vf;
            state_d  = S_DONE;
          end
        end
      end
      S_SHIFT: begin
        result_d = step_res;
        cnt_d    = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) begin
          zf_d    = (step_res == '0);
          sf_d    = step_res[WIDTH-1];
          cf_d    = 1'b0;
          vf_d    = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any shift in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      cnt_q    <= '0;
      sel_q    <= '0;
      zf_q     <= 1'b0;
      cf_q     <= 1'b0;
      vf_q     <= 1'b0;
      sf_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      zf_q     <= zf_d;
      cf_q     <= cf_d;
      vf_q     <= vf_d;
      sf_q     <= sf_d;
    end
  end

endmodule
